// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 64x64 1-bit frame writer.
//   Image geometry, custom-instruction opcodes, error result, FSM states.
package vga_pkg;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int ADDR_W = 12;  // log2(IMG_W*IMG_H)
  localparam int XY_W   = 6;   // log2(IMG_W)
  localparam int NPIX   = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    OP_PIXEL  = 2'b00,
    OP_FILL   = 2'b01,
    OP_HLINE  = 2'b10,
    OP_STATUS = 2'b11
  } op_e;

  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/vga_frame_writer_if.sv
// vga_frame_writer_if: custom-instruction handshake plus RAM write port.
//   slave  : the frame writer (takes clk_en/start/dataa/datab, drives
//            result/done and the RAM write signals).
//   master : the CPU/bench side.
interface vga_frame_writer_if;
  import vga_pkg::*;

  logic              clk_en;
  logic              start;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic [31:0]       result;
  logic              done;
  logic              wr_data;
  logic [ADDR_W-1:0] wr_address;
  logic              wr_en;

  modport slave (
    input  clk_en, start, dataa, datab,
    output result, done, wr_data, wr_address, wr_en
  );

  modport master (
    output clk_en, start, dataa, datab,
    input  result, done, wr_data, wr_address, wr_en
  );
endinterface

// File: rtl/vga_addr_sweeper.sv
// vga_addr_sweeper: loadable start/end address counter.
//   clk, reset   : clock, synchronous active-high reset
//   clk_en       : global hold; nothing moves while low
//   load         : capture start_addr/end_addr
//   advance      : step addr by one (stops once addr reaches the end)
//   addr, last   : current address, addr==end flag
module vga_addr_sweeper
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      end_q <= '0;
    end else if (clk_en) begin
      if (load) begin
        addr  <= start_addr;
        end_q <= end_addr;
      end else if (advance && !last) begin
        // Saturate at the end address so a FILL never wraps into a second pass.
        addr <= addr + 1'b1;
      end
    end
  end

  assign last = (addr == end_q);
endmodule

// File: rtl/vga_frame_writer.sv
// vga_frame_writer: Nios II multicycle custom instruction that writes the
// 64x64 1-bit image RAM. Ops: PIXEL, FILL, HLINE, STATUS (write count).
//   clk    : CPU clock, also the RAM write clock
//   reset  : synchronous active-high reset
//   bus    : slave modport (clk_en/start/dataa/datab in,
//            result/done/wr_data/wr_address/wr_en out)
module vga_frame_writer
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  vga_frame_writer_if.slave  bus
);
  state_e            state, nxt;
  logic [31:0]       res_q;
  logic              data_q;
  logic [31:0]       wr_cnt;
  logic [ADDR_W-1:0] sw_start, sw_end, sw_addr;
  logic              sw_last, accept;

  op_e             op;
  logic [XY_W-1:0] x0, y, x1;
  logic            hl_ok;
  logic            unused_bits;

  assign op     = op_e'(bus.dataa[31:30]);
  assign x0     = bus.dataa[5:0];
  assign y      = bus.dataa[11:6];
  assign x1     = bus.dataa[17:12];
  assign hl_ok  = (x1 >= x0);
  assign accept = (state == S_IDLE) && bus.start && bus.clk_en;
  assign unused_bits = &{1'b0, bus.dataa[29:18], bus.datab[31:1]};

  // FILL sweeps the whole RAM; PIXEL is a one-address sweep.
  always_comb begin
    sw_start = {y, x0};
    sw_end   = {y, x1};
    if (op == OP_FILL) begin
      sw_start = '0;
      sw_end   = '1;
    end else if (op == OP_PIXEL) begin
      sw_end   = {y, x0};
    end
  end

  vga_addr_sweeper u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (bus.clk_en),
    .load       (accept),
    .advance    (state == S_RUN),
    .start_addr (sw_start),
    .end_addr   (sw_end),
    .addr       (sw_addr),
    .last       (sw_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (bus.clk_en) begin
      unique case (state)
        S_IDLE: if (bus.start) begin
          unique case (op)
            OP_PIXEL:  nxt = S_WRITE;
            OP_FILL:   nxt = S_RUN;
            OP_HLINE:  nxt = hl_ok ? S_RUN : S_DONE;
            OP_STATUS: nxt = S_DONE;
            default:   nxt = S_IDLE;
          endcase
        end
        S_WRITE: nxt = S_DONE;
        S_RUN:   if (sw_last) nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Result is fixed at accept time; STATUS samples the counter then, which
  // is exact because no writes happen while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      data_q <= 1'b0;
    end else if (accept) begin
      data_q <= bus.datab[0];
      unique case (op)
        OP_PIXEL:  res_q <= 32'({y, x0});
        OP_FILL:   res_q <= 32'(NPIX);
        OP_HLINE:  res_q <= hl_ok ? (32'(x1) - 32'(x0) + 32'd1) : ERR_RESULT;
        OP_STATUS: res_q <= wr_cnt;
        default:   res_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           wr_cnt <= '0;
    else if (bus.wr_en)  wr_cnt <= wr_cnt + 32'd1;
  end

  assign bus.wr_en      = bus.clk_en && ((state == S_WRITE) || (state == S_RUN));
  assign bus.wr_address = sw_addr;
  assign bus.wr_data    = data_q;
  assign bus.done       = bus.clk_en && (state == S_DONE);
  assign bus.result     = bus.done ? res_q : 32'd0;
endmodule

// File: tb/tb_vga_frame_writer.sv
module tb_vga_frame_writer;
  import vga_pkg::*;

  logic clk, reset;
  vga_frame_writer_if bus();

  vga_frame_writer dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Observations from one operation
  int          obs_addr[$], obs_data[$], obs_cyc[$], obs_stall_addr[$];
  int          obs_done_n, obs_done_cyc;
  logic [31:0] obs_res;

  // Reference model state
  int          exp_addr[$];
  logic [31:0] exp_res;
  int          exp_lat;
  logic [31:0] exp_cnt;

  function automatic logic [31:0] mk(input logic [1:0] op, input int y, x0, x1);
    mk = {op, 12'd0, 6'(x1), 6'(y), 6'(x0)};
  endfunction

  // Model: what addresses an op writes, what it returns, when done appears.
  task automatic model_op(input logic [31:0] a, input int stall_n);
    int op = int'(a[31:30]);
    int x0 = int'(a[5:0]);
    int y  = int'(a[11:6]);
    int x1 = int'(a[17:12]);
    exp_addr.delete();
    case (op)
      0: begin exp_addr.push_back(y * IMG_W + x0); exp_res = y * IMG_W + x0; end
      1: begin for (int i = 0; i < IMG_W * IMG_H; i++) exp_addr.push_back(i); exp_res = IMG_W * IMG_H; end
      2: if (x1 < x0) exp_res = 32'hFFFF_FFFF;
         else begin
           for (int i = x0; i <= x1; i++) exp_addr.push_back(y * IMG_W + i);
           exp_res = x1 - x0 + 1;
         end
      default: exp_res = exp_cnt;
    endcase
    exp_lat = exp_addr.size() + 1 + stall_n;
    exp_cnt = exp_cnt + exp_addr.size();
  endtask

  function automatic int first_diff();
    if (obs_addr.size() != exp_addr.size()) return -2;
    foreach (obs_addr[i]) if (obs_addr[i] != exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic int count_data_ne(input int v);
    int n = 0;
    foreach (obs_data[i]) if (obs_data[i] != v) n++;
    return n;
  endfunction

  // Runs one op from posedge+1; start at cycle 0. Optional clk_en stall and
  // a spurious start pulse. Returns at posedge+1.
  task automatic run_op(input logic [31:0] a, b, input int stall_c, stall_n, spur_c, budget);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_stall_addr.delete();
    obs_done_n = 0; obs_done_cyc = -1; obs_res = '0;
    bus.dataa = a; bus.datab = b; bus.start = 1'b1; bus.clk_en = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (bus.wr_en) begin
        obs_addr.push_back(int'(bus.wr_address));
        obs_data.push_back(int'(bus.wr_data));
        obs_cyc.push_back(cyc);
      end
      if (!bus.clk_en) obs_stall_addr.push_back(int'(bus.wr_address));
      if (bus.done) begin
        obs_done_n++;
        if (obs_done_n == 1) begin obs_done_cyc = cyc; obs_res = bus.result; end
      end
      if (obs_done_n > 0 && cyc >= obs_done_cyc + 3) break;
      @(posedge clk); #1;
      bus.start  = (cyc + 1 == spur_c);
      if (cyc + 1 == spur_c) bus.dataa = mk(2'b00, 1, 2, 0);
      bus.clk_en = !(cyc + 1 >= stall_c && cyc + 1 < stall_c + stall_n);
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.clk_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.clk_en = 1'b1; bus.dataa = '0; bus.datab = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.result, bus.done, bus.wr_en, bus.wr_data, bus.wr_address} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got result=%h done=%b wr_en=%b wr_data=%b addr=%0d, want all 0",
               bus.result, bus.done, bus.wr_en, bus.wr_data, bus.wr_address);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pixel();
    logic [31:0] a = mk(2'b00, 5, 10, 0);
    model_op(a, 0);
    run_op(a, 32'd1, -1, 0, -1, 20);
    n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL pixel_addr: got %p want %p", obs_addr, exp_addr); end
    n_cmp++; if (obs_addr.size() != 1 || obs_cyc[0] != 1) begin n_fail++; $display("FAIL pixel_wr_cycle: got %p want [1]", obs_cyc); end
    n_cmp++; if (count_data_ne(1) != 0) begin n_fail++; $display("FAIL pixel_data: got %p want all 1", obs_data); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat) begin n_fail++; $display("FAIL pixel_done: got %0d pulses at %0d, want 1 at %0d", obs_done_n, obs_done_cyc, exp_lat); end
    n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL pixel_result: got %0d want %0d", obs_res, exp_res); end
  endtask

  task automatic test_fill_status();
    logic [31:0] a = mk(2'b01, 0, 0, 0);
    model_op(a, 0);
    run_op(a, 32'hFFFF_FFFE, -1, 0, -1, 4200);
    n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL fill_addr: %0d writes, first diff %0d, want %0d writes", obs_addr.size(), first_diff(), exp_addr.size()); end
    n_cmp++; if (count_data_ne(0) != 0) begin n_fail++; $display("FAIL fill_data: %0d writes with data!=0, want 0", count_data_ne(0)); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat) begin n_fail++; $display("FAIL fill_done: got %0d pulses at %0d, want 1 at %0d", obs_done_n, obs_done_cyc, exp_lat); end
    n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL fill_result: got %0d want %0d", obs_res, exp_res); end
    a = mk(2'b11, 0, 0, 0);
    model_op(a, 0);
    run_op(a, 32'd0, -1, 0, -1, 20);
    n_cmp++; if (obs_res !== exp_res || obs_done_cyc != 1 || obs_addr.size() != 0) begin
      n_fail++; $display("FAIL fill_status: got %0d at cycle %0d (%0d writes), want %0d at 1", obs_res, obs_done_cyc, obs_addr.size(), exp_res); end
  endtask

  task automatic test_hline();
    logic [31:0] a = mk(2'b10, 63, 60, 63);
    model_op(a, 0);
    run_op(a, 32'd1, -1, 0, -1, 30);
    n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL hline_addr: got %p want %p", obs_addr, exp_addr); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat || obs_res !== exp_res) begin
      n_fail++; $display("FAIL hline_done: got %0d pulses at %0d res %0d, want 1 at %0d res %0d", obs_done_n, obs_done_cyc, obs_res, exp_lat, exp_res); end
    a = mk(2'b10, 9, 20, 10);
    model_op(a, 0);
    run_op(a, 32'd1, -1, 0, -1, 30);
    n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL hline_err_writes: got %0d writes want 0", obs_addr.size()); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != 1 || obs_res !== exp_res) begin
      n_fail++; $display("FAIL hline_err_done: got %0d pulses at %0d res %h, want 1 at 1 res %h", obs_done_n, obs_done_cyc, obs_res, exp_res); end
  endtask

  task automatic test_stall();
    logic [31:0] a = mk(2'b01, 0, 0, 0);
    int stall_c = 50;
    model_op(a, 3);
    run_op(a, 32'd1, stall_c, 3, -1, 4200);
    n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL stall_addr: %0d writes, first diff %0d, want %0d", obs_addr.size(), first_diff(), exp_addr.size()); end
    n_cmp++; if (obs_stall_addr.size() != 3 || obs_stall_addr[0] != stall_c - 1 || obs_stall_addr[2] != stall_c - 1) begin
      n_fail++; $display("FAIL stall_hold: got %p want three x %0d", obs_stall_addr, stall_c - 1); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat || obs_res !== exp_res) begin
      n_fail++; $display("FAIL stall_done: got %0d pulses at %0d res %0d, want 1 at %0d res %0d", obs_done_n, obs_done_cyc, obs_res, exp_lat, exp_res); end
  endtask

  task automatic test_reset_mid_fill();
    int nwr = 0, ndone = 0;
    bus.dataa = mk(2'b01, 0, 0, 0); bus.datab = 32'd1; bus.start = 1'b1; bus.clk_en = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (bus.wr_en) nwr++;
      if (nwr == 100) begin reset = 1'b1; break; end
      @(posedge clk); #1 bus.start = 1'b0;
    end
    n_cmp++; if (nwr != 100) begin n_fail++; $display("FAIL rst_mid_reach: got %0d writes want 100", nwr); end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.result, bus.done, bus.wr_en, bus.wr_data, bus.wr_address} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: result=%h done=%b wr_en=%b wr_data=%b addr=%0d, want all 0",
                         bus.result, bus.done, bus.wr_en, bus.wr_data, bus.wr_address); end
    reset = 1'b0; bus.start = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.done || bus.wr_en) ndone++; end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", ndone); end
    @(posedge clk); #1;
    model_op(mk(2'b11, 0, 0, 0), 0);
    run_op(mk(2'b11, 0, 0, 0), 32'd0, -1, 0, -1, 20);
    n_cmp++; if (obs_res !== exp_res || obs_done_cyc != 1) begin n_fail++; $display("FAIL rst_mid_status: got %0d at %0d want %0d at 1", obs_res, obs_done_cyc, exp_res); end
  endtask

  task automatic test_spurious_start();
    logic [31:0] a = mk(2'b10, 7, 3, 40);
    model_op(a, 0);
    run_op(a, 32'd1, -1, 0, 10, 80);
    n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL spur_addr: %0d writes, first diff %0d, want %0d", obs_addr.size(), first_diff(), exp_addr.size()); end
    n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat || obs_res !== exp_res) begin
      n_fail++; $display("FAIL spur_done: got %0d pulses at %0d res %0d, want 1 at %0d res %0d", obs_done_n, obs_done_cyc, obs_res, exp_lat, exp_res); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2)) 0: op = 2'b00; 1: op = 2'b10; default: op = 2'b11; endcase
      a = mk(op, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      b = $urandom;
      model_op(a, 0);
      run_op(a, b, -1, 0, -1, 100);
      n_cmp++; if (first_diff() != -1) begin n_fail++; $display("FAIL rand%0d_addr: got %p want %p", it, obs_addr, exp_addr); end
      n_cmp++; if (count_data_ne(int'(b[0])) != 0) begin n_fail++; $display("FAIL rand%0d_data: got %p want all %0d", it, obs_data, b[0]); end
      n_cmp++; if (obs_done_n != 1 || obs_done_cyc != exp_lat || obs_res !== exp_res) begin
        n_fail++; $display("FAIL rand%0d_done: got %0d pulses at %0d res %h, want 1 at %0d res %h", it, obs_done_n, obs_done_cyc, obs_res, exp_lat, exp_res); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_status();
    test_pixel();
    test_hline();
    test_stall();
    test_spurious_start();
    test_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
